// File: rtl/pit_request_arbiter.sv
// Serialises interest (lookup-or-insert) and data (lookup-and-mark) requests onto one PIT lookup engine.
// Optional WAIT timeout is built when the macro PIT_ARB_TIMEOUT_EN is defined.
module pit_request_arbiter #(
  parameter int PREFIX_W       = 64,
  parameter int LEN_W          = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                int_valid,
  output logic                int_ready,
  input  logic [PREFIX_W-1:0] int_prefix,
  input  logic [LEN_W-1:0]    int_len,
  input  logic                dat_valid,
  output logic                dat_ready,
  input  logic [PREFIX_W-1:0] dat_prefix,
  input  logic [LEN_W-1:0]    dat_len,
  output logic [PREFIX_W-1:0] tbl_prefix,
  output logic [LEN_W-1:0]    tbl_len,
  output logic [PREFIX_W-1:0] tbl_pit_out_prefix,
  output logic [LEN_W-1:0]    tbl_pit_out_len,
  output logic                tbl_out_bit,
  output logic                tbl_prefix_ready,
  input  logic [63:0]         tbl_entry,
  input  logic                tbl_pit_in_bit,
  input  logic                tbl_rejected,
  output logic                rsp_valid,
  output logic                rsp_src,
  output logic                rsp_hit,
  output logic                rsp_timeout,
  output logic [63:0]         rsp_entry,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t              state_q, state_d;
  logic                issue_cnt_q, issue_cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                src_q, src_d;
  logic                rej_prev_q, rej_prev_d;
  logic [PREFIX_W-1:0] tbl_prefix_q, tbl_prefix_d;
  logic [LEN_W-1:0]    tbl_len_q, tbl_len_d;
  logic [PREFIX_W-1:0] pit_out_prefix_q, pit_out_prefix_d;
  logic [LEN_W-1:0]    pit_out_len_q, pit_out_len_d;
  logic                rsp_src_q, rsp_src_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [63:0]         rsp_entry_q, rsp_entry_d;

  logic grant_int, grant_dat, xfer, wait_st;
  logic hit_evt, rej_evt, tmo_evt, done;

  // Round-robin: on contention the requester not granted last time wins.
  assign grant_int = int_valid & (~dat_valid | last_grant_q);
  assign grant_dat = dat_valid & (~int_valid | ~last_grant_q);
  assign xfer      = (state_q == S_IDLE) & (int_valid | dat_valid);
  assign wait_st   = (state_q == S_WAIT);

  // The table holds rejected high, so only its rising edge signals completion.
  assign hit_evt = wait_st & tbl_pit_in_bit;
  assign rej_evt = wait_st & tbl_rejected & ~rej_prev_q;
  assign done    = hit_evt | rej_evt | tmo_evt;

`ifdef PIT_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_ISSUE) tmo_cnt_d = '0;
    else if (wait_st)       tmo_cnt_d = tmo_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_evt = wait_st & (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_evt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (int_valid | dat_valid) state_d = S_ISSUE;
      S_ISSUE: if (issue_cnt_q)           state_d = S_WAIT;
      S_WAIT:  if (done)                  state_d = S_RESP;
      S_RESP:                             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_cnt_d      = 1'b0;
    last_grant_d     = last_grant_q;
    src_d            = src_q;
    rej_prev_d       = rej_prev_q;
    tbl_prefix_d     = tbl_prefix_q;
    tbl_len_d        = tbl_len_q;
    pit_out_prefix_d = pit_out_prefix_q;
    pit_out_len_d    = pit_out_len_q;
    rsp_src_d        = rsp_src_q;
    rsp_hit_d        = rsp_hit_q;
    rsp_timeout_d    = rsp_timeout_q;
    rsp_entry_d      = rsp_entry_q;
    if (state_q == S_ISSUE) issue_cnt_d = ~issue_cnt_q;
    // Operands land directly in the output pair so they are valid from the first ISSUE cycle.
    if (xfer) begin
      src_d = grant_dat;
      if (grant_int) begin
        tbl_prefix_d = int_prefix;
        tbl_len_d    = int_len;
      end else begin
        pit_out_prefix_d = dat_prefix;
        pit_out_len_d    = dat_len;
      end
    end
    if (wait_st) begin
      rej_prev_d = tbl_rejected;
      if (done) begin
        last_grant_d  = src_q;
        rsp_src_d     = src_q;
        rsp_hit_d     = hit_evt;
        rsp_timeout_d = tmo_evt & ~hit_evt & ~rej_evt;
        rsp_entry_d   = hit_evt ? tbl_entry : 64'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q      <= 1'b0;
      last_grant_q     <= 1'b1;
      src_q            <= 1'b0;
      rej_prev_q       <= 1'b0;
      tbl_prefix_q     <= '0;
      tbl_len_q        <= '0;
      pit_out_prefix_q <= '0;
      pit_out_len_q    <= '0;
      rsp_src_q        <= 1'b0;
      rsp_hit_q        <= 1'b0;
      rsp_timeout_q    <= 1'b0;
      rsp_entry_q      <= '0;
    end else begin
      issue_cnt_q      <= issue_cnt_d;
      last_grant_q     <= last_grant_d;
      src_q            <= src_d;
      rej_prev_q       <= rej_prev_d;
      tbl_prefix_q     <= tbl_prefix_d;
      tbl_len_q        <= tbl_len_d;
      pit_out_prefix_q <= pit_out_prefix_d;
      pit_out_len_q    <= pit_out_len_d;
      rsp_src_q        <= rsp_src_d;
      rsp_hit_q        <= rsp_hit_d;
      rsp_timeout_q    <= rsp_timeout_d;
      rsp_entry_q      <= rsp_entry_d;
    end
  end

  // Strobes decode from the async-reset state so they drop the instant rst rises.
  always_comb begin
    int_ready        = (state_q == S_IDLE) & grant_int;
    dat_ready        = (state_q == S_IDLE) & grant_dat;
    tbl_out_bit      = (state_q == S_ISSUE) & ~src_q;
    tbl_prefix_ready = (state_q == S_ISSUE) & src_q;
    rsp_valid        = (state_q == S_RESP);
    busy             = (state_q != S_IDLE);
  end

  assign tbl_prefix         = tbl_prefix_q;
  assign tbl_len            = tbl_len_q;
  assign tbl_pit_out_prefix = pit_out_prefix_q;
  assign tbl_pit_out_len    = pit_out_len_q;
  assign rsp_src            = rsp_src_q;
  assign rsp_hit            = rsp_hit_q;
  assign rsp_timeout        = rsp_timeout_q;
  assign rsp_entry          = rsp_entry_q;

endmodule

// File: tb/tb_pit_request_arbiter.sv
// Scoreboard bench for pit_request_arbiter: directed requests push expected responses, a monitor pops them.
module tb_pit_request_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        int_valid, int_ready, dat_valid, dat_ready;
  logic [63:0] int_prefix, dat_prefix, tbl_prefix, tbl_pit_out_prefix;
  logic [5:0]  int_len, dat_len, tbl_len, tbl_pit_out_len;
  logic        tbl_out_bit, tbl_prefix_ready;
  logic [63:0] tbl_entry;
  logic        tbl_pit_in_bit, tbl_rejected;
  logic        rsp_valid, rsp_src, rsp_hit, rsp_timeout, busy;
  logic [63:0] rsp_entry;

  pit_request_arbiter #(.PREFIX_W(64), .LEN_W(6), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_ready(int_ready), .int_prefix(int_prefix), .int_len(int_len),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_prefix(dat_prefix), .dat_len(dat_len),
    .tbl_prefix(tbl_prefix), .tbl_len(tbl_len),
    .tbl_pit_out_prefix(tbl_pit_out_prefix), .tbl_pit_out_len(tbl_pit_out_len),
    .tbl_out_bit(tbl_out_bit), .tbl_prefix_ready(tbl_prefix_ready),
    .tbl_entry(tbl_entry), .tbl_pit_in_bit(tbl_pit_in_bit), .tbl_rejected(tbl_rejected),
    .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_hit(rsp_hit), .rsp_timeout(rsp_timeout),
    .rsp_entry(rsp_entry), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        src;
    logic        hit;
    logic        to;
    logic [63:0] entry;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic src, input logic hit, input logic to, input logic [63:0] entry,
                      input int c);
    sb.push_back('{src, hit, to, entry, c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Presents one request and returns the transfer cycle; leaves the bench one cycle later (first ISSUE).
  task automatic do_req(input logic src, input logic [63:0] pfx, input logic [5:0] len, output int t);
    bit got;
    got = 1'b0;
    t = 0;
    if (src) begin
      dat_valid = 1'b1; dat_prefix = pfx; dat_len = len;
    end else begin
      int_valid = 1'b1; int_prefix = pfx; int_len = len;
    end
    for (int i = 0; i < 10 && !got; i++) begin
      neg();
      if ((src ? dat_ready : int_ready) === 1'b1) begin
        got = 1'b1;
        t = cyc;
      end
      tick();
    end
    chk("req_granted", 64'(got), 64'd1);
    int_valid = 1'b0;
    dat_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_src", 64'(rsp_src), 64'(mon_e.src));
        chk("rsp_hit", 64'(rsp_hit), 64'(mon_e.hit));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.to));
        chk("rsp_entry", rsp_entry, mon_e.entry);
        chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t, t0;
    rst = 1'b1;
    int_valid = 1'b0; dat_valid = 1'b0;
    int_prefix = '0; dat_prefix = '0; int_len = '0; dat_len = '0;
    tbl_entry = '0; tbl_pit_in_bit = 1'b0; tbl_rejected = 1'b0;
    tick(); tick();
    neg();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_strobes", 64'({tbl_out_bit, tbl_prefix_ready}), 64'd0);
    chk("rst_rsp_entry", rsp_entry, 64'd0);
    chk("rst_tbl_prefix", tbl_prefix, 64'd0);
    chk("rst_ready", 64'({int_ready, dat_ready}), 64'd0);
    tick();
    rst = 1'b0;

    // Interest-only hit
    do_req(1'b0, 64'h1234, 6'd16, t);
    int_prefix = 64'hFFFF;
    neg();
    chk("t1_out_bit_c1", 64'(tbl_out_bit), 64'd1);
    chk("t1_prefix_ready_c1", 64'(tbl_prefix_ready), 64'd0);
    chk("t1_tbl_len", 64'(tbl_len), 64'd16);
    chk("t1_busy", 64'(busy), 64'd1);
    tick();
    neg();
    chk("t1_out_bit_c2", 64'(tbl_out_bit), 64'd1);
    chk("t1_tbl_prefix_held", tbl_prefix, 64'h1234);
    tick();
    tbl_pit_in_bit = 1'b1;
    tbl_entry = 64'h8000_0000_0000_0000;
    push(1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, t + 4);
    neg();
    chk("t1_out_bit_wait", 64'(tbl_out_bit), 64'd0);
    tick();
    tbl_pit_in_bit = 1'b0;
    tbl_entry = 64'hDEAD;
    tick();
    neg();
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_entry_hold", rsp_entry, 64'h8000_0000_0000_0000);

    // Simultaneous valids from reset, then a data miss
    rst = 1'b1; tick(); rst = 1'b0;
    int_valid = 1'b1; int_prefix = 64'hA1; int_len = 6'd1;
    dat_valid = 1'b1; dat_prefix = 64'hB2; dat_len = 6'd2;
    neg();
    chk("t2_int_ready", 64'(int_ready), 64'd1);
    chk("t2_dat_ready", 64'(dat_ready), 64'd0);
    t = cyc;
    tick();
    int_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 3) begin
        tbl_pit_in_bit = 1'b1; tbl_entry = 64'h11;
        push(1'b0, 1'b1, 1'b0, 64'h11, t + 4);
      end
      if (i == 4) tbl_pit_in_bit = 1'b0;
      neg();
      chk("t2_dat_ready_held0", 64'(dat_ready), 64'd0);
      chk("t2_prefix_ready_0", 64'(tbl_prefix_ready), 64'd0);
      tick();
    end
    neg();
    chk("t2_dat_ready_granted", 64'(dat_ready), 64'd1);
    tick();
    dat_valid = 1'b0;
    neg();
    chk("t2_prefix_ready_c1", 64'(tbl_prefix_ready), 64'd1);
    chk("t2_out_bit_low", 64'(tbl_out_bit), 64'd0);
    chk("t2_pit_out_prefix", tbl_pit_out_prefix, 64'hB2);
    chk("t2_pit_out_len", 64'(tbl_pit_out_len), 64'd2);
    chk("t2_tbl_prefix_kept", tbl_prefix, 64'hA1);
    tick();
    neg();
    chk("t2_prefix_ready_c2", 64'(tbl_prefix_ready), 64'd1);
    tick();
    tbl_rejected = 1'b1;
    tbl_entry = 64'hFFFF;
    push(1'b1, 1'b0, 1'b0, 64'd0, t + 9);
    neg();
    chk("t2_prefix_ready_wait", 64'(tbl_prefix_ready), 64'd0);
    tick(); tick();

    // Second data miss with rejected already high: no edge, no completion
    do_req(1'b1, 64'hC3, 6'd5, t);
    tick(); tick();
`ifdef PIT_ARB_TIMEOUT_EN
    push(1'b1, 1'b0, 1'b1, 64'd0, t + 19);
    repeat (17) tick();
    neg();
    chk("t3_busy_after_timeout", 64'(busy), 64'd0);
    tick();
`else
    repeat (17) tick();
    neg();
    chk("t3_busy_stuck", 64'(busy), 64'd1);
    chk("t3_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
`endif
    tbl_rejected = 1'b0;

    // Reset pulsed during ISSUE drops the strobe at once
    do_req(1'b0, 64'h77, 6'd3, t);
    #2 rst = 1'b1;
    #1;
    chk("t4_issue_out_bit", 64'(tbl_out_bit), 64'd0);
    chk("t4_issue_busy", 64'(busy), 64'd0);
    tick(); rst = 1'b0;

    // Reset pulsed during WAIT aborts silently
    do_req(1'b0, 64'h55, 6'd8, t);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("t4_wait_busy", 64'(busy), 64'd0);
    chk("t4_wait_strobes", 64'({tbl_out_bit, tbl_prefix_ready}), 64'd0);
    chk("t4_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t4_wait_tbl_prefix", tbl_prefix, 64'd0);
    tick(); tick();
    rst = 1'b0;
    neg();
    chk("t4_after_busy", 64'(busy), 64'd0);
    tick();

    // Both valids held for four transactions: alternate grants, 5-cycle spacing
    int_valid = 1'b1; int_prefix = 64'h0A0A; int_len = 6'd10;
    dat_valid = 1'b1; dat_prefix = 64'h0B0B; dat_len = 6'd11;
    neg();
    chk("t5_first_int_ready", 64'(int_ready), 64'd1);
    chk("t5_first_dat_ready", 64'(dat_ready), 64'd0);
    t0 = cyc;
    for (int off = 1; off <= 20; off++) begin
      tick();
      if (off % 5 == 3) begin
        tbl_pit_in_bit = 1'b1;
        tbl_entry = 64'h100 + 64'(off);
        push(1'((off / 5) % 2), 1'b1, 1'b0, 64'h100 + 64'(off), cyc + 1);
      end else begin
        tbl_pit_in_bit = 1'b0;
      end
      if (off == 19) begin
        int_valid = 1'b0;
        dat_valid = 1'b0;
      end
      neg();
      if (off % 5 == 0 && off < 20) begin
        chk("t5_int_ready", 64'(int_ready), 64'(((off / 5) % 2) == 0));
        chk("t5_dat_ready", 64'(dat_ready), 64'(((off / 5) % 2) == 1));
      end
      if (off % 5 == 1) begin
        chk("t5_out_bit", 64'(tbl_out_bit), 64'(((off / 5) % 2) == 0));
        chk("t5_prefix_ready", 64'(tbl_prefix_ready), 64'(((off / 5) % 2) == 1));
      end
    end
    chk("t5_idle", 64'(busy), 64'd0);

    // Hit and rejected edge in the same cycle: hit wins
    tick();
    do_req(1'b1, 64'hD4, 6'd7, t);
    tick(); tick();
    tbl_pit_in_bit = 1'b1; tbl_rejected = 1'b1; tbl_entry = 64'hABCD;
    push(1'b1, 1'b1, 1'b0, 64'hABCD, t + 4);
    tick();
    tbl_pit_in_bit = 1'b0;
    tick(); tick();
    neg();
    chk("pending_rsp", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
